// File: rtl/md_unit_if.sv
// md_unit_if: E-stage request and HI/LO response bundle for the multiply/divide unit
interface md_unit_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;
  modport master (output start, op, A, B, input busy, HI, LO);
  modport slave (input start, op, A, B, output busy, HI, LO);
endinterface

// File: rtl/md_unit.sv
// md_unit: multi-cycle mult/div responder owning HI/LO; busy is derived from the cycle counter
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input logic      clk,
  input logic      reset,
  md_unit_if.slave md
);
  localparam int MAXC = MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAXC + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d, phi_q, phi_d, plo_q, plo_d;
  logic skip_q, skip_d;
  logic [31:0] bnz, sq, sr, uq, ur;
  logic [63:0] smul, umul;
  logic idle, accept, commit;
  assign idle = cnt_q == '0;
  assign accept = md.start && idle;
  assign commit = cnt_q == CW'(1);
  assign smul = $signed({{32{md.A[31]}}, md.A}) * $signed({{32{md.B[31]}}, md.B});
  assign umul = {32'd0, md.A} * {32'd0, md.B};
  // divisor forced nonzero so the dividers never see 0; zero-divide results are discarded via skip
  assign bnz = md.B == '0 ? 32'd1 : md.B;
  // 33-bit signed divide absorbs the 0x80000000 / -1 overflow case
  assign sq = 32'($signed({md.A[31], md.A}) / $signed({bnz[31], bnz}));
  assign sr = 32'($signed({md.A[31], md.A}) % $signed({bnz[31], bnz}));
  assign uq = md.A / bnz;
  assign ur = md.A % bnz;
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      phi_q  <= '0;
      plo_q  <= '0;
      skip_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      phi_q  <= phi_d;
      plo_q  <= plo_d;
      skip_q <= skip_d;
    end
  end
  always_comb begin
    cnt_d  = idle ? '0 : cnt_q - 1'b1;
    hi_d   = commit && !skip_q ? phi_q : hi_q;
    lo_d   = commit && !skip_q ? plo_q : lo_q;
    phi_d  = phi_q;
    plo_d  = plo_q;
    skip_d = skip_q;
    if (accept) begin
      case (md.op)
        3'd1: begin {phi_d, plo_d} = smul; skip_d = 1'b0; cnt_d = CW'(MULT_CYCLES); end
        3'd2: begin {phi_d, plo_d} = umul; skip_d = 1'b0; cnt_d = CW'(MULT_CYCLES); end
        3'd3: begin {phi_d, plo_d} = {sr, sq}; skip_d = md.B == '0; cnt_d = CW'(DIV_CYCLES); end
        3'd4: begin {phi_d, plo_d} = {ur, uq}; skip_d = md.B == '0; cnt_d = CW'(DIV_CYCLES); end
        3'd5: hi_d = md.A;
        3'd6: lo_d = md.A;
        default: ;
      endcase
    end
  end
  always_comb begin
    md.busy = !idle;
    md.HI   = hi_q;
    md.LO   = lo_q;
  end
  always_ff @(posedge clk)
    if (!reset && md.start) assert (idle) else $warning("md_unit: start ignored while busy");
endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: randomized scoreboard bench for md_unit against a longint arithmetic model
module tb_md_unit;
  localparam int MC = 5;
  localparam int DC = 10;
  typedef struct { logic [31:0] hi; logic [31:0] lo; int n; } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic rst_seen = 1'b0;
  md_unit_if ifc();
  md_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (.clk(clk), .reset(reset), .md(ifc));
  exp_t q[$];
  int vecs = 0;
  int errs = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  always #5 clk = ~clk;
  always @(posedge clk) rst_seen <= reset;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask
  // monitor: every busy falling edge (outside reset) must match the oldest queued result
  int bcnt = 0;
  bit pbusy = 0;
  always @(negedge clk) begin
    if (rst_seen) begin
      bcnt = 0;
      pbusy = 0;
    end else if (ifc.busy) begin
      bcnt++;
      pbusy = 1;
    end else if (pbusy) begin
      pbusy = 0;
      if (q.size() == 0) begin
        vecs++;
        errs++;
        $display("FAIL unexpected_commit: HI=%08h LO=%08h with empty scoreboard", ifc.HI, ifc.LO);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("commit_hi", ifc.HI, e.hi);
        chk("commit_lo", ifc.LO, e.lo);
        chk("busy_len", 32'(bcnt), 32'(e.n));
      end
      bcnt = 0;
    end
  end
  // caller sits at a negedge; returns at the negedge where the unit is idle again
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input int poke);
    logic [31:0] eh, el;
    longint sp, sq, sr;
    longint unsigned up;
    int n, k;
    eh = m_hi;
    el = m_lo;
    n = 0;
    case (o)
      3'd1: begin sp = longint'($signed(a)) * longint'($signed(b)); {eh, el} = sp; n = MC; end
      3'd2: begin up = longint'({32'd0, a}) * longint'({32'd0, b}); {eh, el} = up; n = MC; end
      3'd3: begin
        n = DC;
        if (b != 0) begin
          sq = longint'($signed(a)) / longint'($signed(b));
          sr = longint'($signed(a)) % longint'($signed(b));
          el = sq[31:0];
          eh = sr[31:0];
        end
      end
      3'd4: begin n = DC; if (b != 0) begin el = a / b; eh = a % b; end end
      3'd5: eh = a;
      3'd6: el = a;
      default: ;
    endcase
    m_hi = eh;
    m_lo = el;
    if (n != 0) q.push_back('{eh, el, n});
    ifc.start = 1'b1;
    ifc.op = o;
    ifc.A = a;
    ifc.B = b;
    @(negedge clk);
    ifc.start = 1'b0;
    ifc.op = 3'd0;
    if (n != 0) begin
      k = 0;
      while (ifc.busy && k < 50) begin
        if (poke != 0 && k == poke) begin
          ifc.start = 1'b1;
          ifc.op = 3'd6;
          ifc.A = $urandom;
        end else ifc.start = 1'b0;
        @(negedge clk);
        k++;
      end
      ifc.start = 1'b0;
      if (k >= 50) begin
        vecs++;
        errs++;
        $display("FAIL busy_timeout: busy still %0b after %0d cycles", ifc.busy, k);
      end
    end else begin
      chk("nonmd_busy", 32'(ifc.busy), 32'd0);
      chk("nonmd_hi", ifc.HI, eh);
      chk("nonmd_lo", ifc.LO, el);
    end
  endtask
  initial begin
    logic [2:0] o;
    logic [31:0] a, b;
    ifc.start = 1'b0;
    ifc.op = 3'd0;
    ifc.A = '0;
    ifc.B = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("idle_busy", 32'(ifc.busy), 32'd0);
      chk("idle_hi", ifc.HI, 32'd0);
      chk("idle_lo", ifc.LO, 32'd0);
    end
    issue(3'd1, 32'hFFFFFFFE, 32'd3, 0);
    chk("mult_hi", ifc.HI, 32'hFFFFFFFF);
    chk("mult_lo", ifc.LO, 32'hFFFFFFFA);
    issue(3'd2, 32'hFFFFFFFE, 32'd3, 0);
    chk("multu_hi", ifc.HI, 32'h00000002);
    chk("multu_lo", ifc.LO, 32'hFFFFFFFA);
    issue(3'd3, 32'hFFFFFFF9, 32'd2, 0);
    chk("div_neg_hi", ifc.HI, 32'hFFFFFFFF);
    chk("div_neg_lo", ifc.LO, 32'hFFFFFFFD);
    issue(3'd4, 32'd7, 32'd2, 0);
    chk("divu_hi", ifc.HI, 32'd1);
    chk("divu_lo", ifc.LO, 32'd3);
    issue(3'd3, 32'h80000000, 32'hFFFFFFFF, 0);
    chk("div_ovf_hi", ifc.HI, 32'd0);
    chk("div_ovf_lo", ifc.LO, 32'h80000000);
    issue(3'd5, 32'h11, 32'd0, 0);
    issue(3'd6, 32'h22, 32'd0, 0);
    issue(3'd3, 32'h1234, 32'd0, 0);
    chk("div0_hi", ifc.HI, 32'h11);
    chk("div0_lo", ifc.LO, 32'h22);
    issue(3'd5, 32'hDEADBEEF, 32'd0, 0);
    chk("mthi_hi", ifc.HI, 32'hDEADBEEF);
    chk("mthi_lo", ifc.LO, 32'h22);
    issue(3'd1, 32'd1000, 32'hFFFFFFF0, 2);
    issue(3'd2, 32'd3, 32'd4, 0);
    chk("b2b_multu_lo", ifc.LO, 32'd12);
    chk("b2b_multu_hi", ifc.HI, 32'd0);
    issue(3'd4, 32'd100, 32'd7, 0);
    chk("b2b_divu_lo", ifc.LO, 32'd14);
    chk("b2b_divu_hi", ifc.HI, 32'd2);
    ifc.start = 1'b1;
    ifc.op = 3'd1;
    ifc.A = 32'h12345678;
    ifc.B = 32'h9ABCDEF0;
    @(negedge clk);
    ifc.start = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m_hi = '0;
    m_lo = '0;
    chk("rst_mid_busy", 32'(ifc.busy), 32'd0);
    chk("rst_mid_hi", ifc.HI, 32'd0);
    chk("rst_mid_lo", ifc.LO, 32'd0);
    repeat (8) @(negedge clk);
    chk("rst_late_busy", 32'(ifc.busy), 32'd0);
    chk("rst_late_hi", ifc.HI, 32'd0);
    chk("rst_late_lo", ifc.LO, 32'd0);
    repeat (60) begin
      o = 3'($urandom_range(0, 7));
      a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 200)) : $urandom;
      b = ($urandom_range(0, 7) == 0) ? 32'd0 :
          ($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 20)) : $urandom;
      if ($urandom_range(0, 3) == 0) @(negedge clk);
      issue(o, a, b, 0);
    end
    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 32'(q.size()), 32'd0);
    chk("final_hi", ifc.HI, m_hi);
    chk("final_lo", ifc.LO, m_lo);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Multi-cycle multiply/divide responder for the 5-stage MIPS pipeline; sits in the E stage beside the ALU.
- E-stage control is the initiator: it issues mult/multu/div/divu/mthi/mtlo with a one-cycle start.
- The block answers with busy and owns the HI/LO registers.
- The stall unit combines start|busy with a D-stage MD-class instruction to freeze F/D and bubble E, exactly as for load-use stalls.

Parameters:
- MULT_CYCLES, 5, cycles busy stays high for mult/multu (>=1).
- DIV_CYCLES, 10, cycles busy stays high for div/divu (>=1).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high; clears all state.
- start  input  1  one-cycle request strobe from E stage.
- op  input  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none).
- A  input  32  rs operand (forwarded value).
- B  input  32  rt operand (forwarded value).
- busy  output  1  high while a mult/div is in flight.
- HI  output  32  architectural HI register.
- LO  output  32  architectural LO register.

Behaviour:
- Reset: at any rising edge with reset=1, busy=0, HI=0, LO=0, counter=0, pending results=0. Reset has priority over start and over an in-flight operation: the operation is aborted and no HI/LO commit occurs.
- States: IDLE (busy=0) and RUN (busy=1). The state is the counter: 0 means IDLE, nonzero means RUN.
- Accept rule: start=1, busy=0 and op in 1..4 at edge e0.
  - Latch the computed result into pending_hi/pending_lo.
  - Load counter with MULT_CYCLES or DIV_CYCLES; busy=1 from e0.
- RUN: counter decrements each edge. At the edge where it reaches 0:
  - HI<=pending_hi and LO<=pending_lo, busy<=0.
  - busy is therefore high for exactly N cycles, and new HI/LO are visible the cycle busy falls.
- start while busy=1 is ignored entirely; the pipeline guarantees this never happens via stall. An assertion flags it in simulation.
- mthi/mtlo: start=1, busy=0, op 5/6 → HI<=A or LO<=A at that edge. busy stays 0 and the other register is unchanged.
- op 0 or 7 with start=1: no effect.
- Arithmetic:
  - mult: signed 32x32→64, {HI,LO}=A*B.
  - multu: unsigned 32x32→64.
  - div: LO=quotient truncated toward zero, HI=remainder with the sign of the dividend.
  - div with A=0x80000000, B=0xFFFFFFFF: LO=0x80000000, HI=0.
  - divu: unsigned quotient/remainder.
  - B=0 for div/divu: the operation still occupies DIV_CYCLES but HI/LO are left unchanged at commit.
- Reads: HI/LO are plain register outputs (mfhi/mflo mux lives outside). During busy they hold the old values; the stall unit stalls mfhi/mflo in D while start|busy.
- No combinational path from inputs to busy/HI/LO; all outputs are registered.
- Back-to-back: a new start is accepted in the same cycle busy is 0 after commit. There are no idle gap cycles.

Test Plan:
- Reset then idle: hold reset 2 cycles, release → busy=0, HI=0, LO=0, stays so with start=0.
- Signed mult: start, op=1, A=0xFFFFFFFE, B=3 → busy=1 for 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA. Unsigned multu with the same operands → HI=0x00000002, LO=0xFFFFFFFA.
- Division corners:
  - div A=-7 (0xFFFFFFF9), B=2 → after 10 busy cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - divu A=7, B=2 → LO=3, HI=1.
  - div 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
  - div by 0 with prior HI=0x11, LO=0x22 → busy 10 cycles, HI/LO stay 0x11/0x22.
- mthi/mtlo and ignored start:
  - mthi A=0xDEADBEEF → HI updates next edge, busy never rises, LO unchanged.
  - mult issued, then start mtlo while busy → ignored, and the mult result is committed intact.
- Reset mid-op: start mult, assert reset on busy cycle 3 → busy=0, HI=LO=0 next edge, with no late commit afterwards.
- Back-to-back: multu 3*4 then divu 100/7 issued the same cycle busy falls → HI=0, LO=12, then 10 cycles later LO=14, HI=2.
